// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle FORWARD/ADD/AND/OR plus iterative MUL, SLL, SRA and ROR.
// Operands are captured under a START/BUSY/DONE handshake; RESULT only moves on completion.
module alu_multicycle #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        OP_FWD = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_MUL = 3'b100,
        OP_SLL = 3'b101,
        OP_SRA = 3'b110,
        OP_ROR = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] n_c;
    logic [WIDTH-1:0] quick_c;
    logic [WIDTH-1:0] a_step_c, b_step_c, acc_step_c;

    // Iteration count for the incoming request; zero means a single-edge op.
    always_comb begin
        n_c = '0;
        case (op_e'(SELECT))
            OP_MUL:         n_c = CNT_W'(WIDTH);
            OP_SLL, OP_SRA: n_c = (DATA2 >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(DATA2);
            OP_ROR:         n_c = CNT_W'(DATA2 % WIDTH'(WIDTH));
            default:        n_c = '0;
        endcase
    end

    // Result of a zero-iteration request; shifts/rotates by zero pass DATA1 through.
    always_comb begin
        quick_c = DATA1;
        case (op_e'(SELECT))
            OP_FWD:  quick_c = DATA2;
            OP_ADD:  quick_c = DATA1 + DATA2;
            OP_AND:  quick_c = DATA1 & DATA2;
            OP_OR:   quick_c = DATA1 | DATA2;
            default: quick_c = DATA1;
        endcase
    end

    // One iteration: MUL is shift-add on the multiplier LSB, shifts move one bit.
    always_comb begin
        a_step_c   = a_q;
        b_step_c   = b_q;
        acc_step_c = acc_q;
        case (op_q)
            OP_MUL: begin
                acc_step_c = b_q[0] ? (acc_q + a_q) : acc_q;
                a_step_c   = a_q << 1;
                b_step_c   = b_q >> 1;
            end
            OP_SLL:  a_step_c = a_q << 1;
            OP_SRA:  a_step_c = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
            OP_ROR:  a_step_c = {a_q[0], a_q[WIDTH-1:1]};
            default: a_step_c = a_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    op_d  = op_e'(SELECT);
                    a_d   = DATA1;
                    b_d   = DATA2;
                    acc_d = '0;
                    if (n_c == '0) begin
                        result_d = quick_c;
                        done_d   = 1'b1;
                    end else begin
                        cnt_d   = n_c;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                a_d   = a_step_c;
                b_d   = b_step_c;
                acc_d = acc_step_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    result_d = (op_q == OP_MUL) ? acc_step_c : a_step_c;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            op_q     <= OP_FWD;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign RESULT = result_q;
    assign ZERO   = (result_q == '0);
    assign BUSY   = (state_q == S_RUN);
    assign DONE   = done_q;

endmodule
